// File: rtl/ddr3_arb_pkg.sv
// Shared types and helpers for the DDR3 port arbiter: FSM states, IP command codes,
// and the byte-mask builder for a 32-bit word placed in a 128-bit burst.
package ddr3_arb_pkg;

    typedef enum logic [2:0] {IDLE, ARB, CMD, RD_WAIT, DONE} arb_state_t;

    localparam logic [2:0] DDR_CMD_WRITE = 3'b000;
    localparam logic [2:0] DDR_CMD_READ  = 3'b001;
    localparam int         LANES         = 4;

    // 1 = byte masked; only the addressed lane can be unmasked.
    function automatic logic [15:0] lane_mask(input logic [1:0] lane, input logic [3:0] byte_en);
        logic [15:0] m;
        m = '1;
        m[{lane, 2'b00} +: 4] = ~byte_en;
        return m;
    endfunction

endpackage

// File: rtl/ddr3_arb_rr_pick.sv
// Combinational masked priority pick: first pending port at or after 'start',
// wrapping from NUM_PORTS-1 back to 0.
module ddr3_arb_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] pending,
    input  logic [IDX_W-1:0]     start,
    output logic [IDX_W-1:0]     grant,
    output logic                 grant_vld
);

    logic [IDX_W-1:0] idx;

    // Scan farthest-first so the closest pending port to 'start' wins last.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = IDX_W'((int'(start) + i) % NUM_PORTS);
            if (pending[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// N-port arbiter between 32-bit sdram clients and the Gowin DDR3 IP user interface.
// Optional coherent per-port read line buffer: define DDR3_LINE_BUFFER_EN.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int PORT_ADDR_WIDTH = 27,
    parameter int DATA_WIDTH      = 32,
    parameter int DQM_WIDTH       = 4,
    parameter int DDR_ADDR_WIDTH  = 29,
    parameter int DDR_DATA_WIDTH  = 128,
    parameter int ARB_MODE        = 1
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    output logic                                        init_complete,
    input  logic [NUM_PORTS-1:0][PORT_ADDR_WIDTH-1:0]   port_addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]        port_data,
    input  logic [NUM_PORTS-1:0][DQM_WIDTH-1:0]         port_byte_en,
    input  logic [NUM_PORTS-1:0]                        port_wr,
    input  logic [NUM_PORTS-1:0]                        port_rd,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]        port_q,
    output logic [NUM_PORTS-1:0]                        port_available,
    output logic [NUM_PORTS-1:0]                        port_ready,
    input  logic                                        init_calib_complete,
    input  logic                                        cmd_ready,
    output logic [2:0]                                  cmd,
    output logic                                        cmd_en,
    output logic [DDR_ADDR_WIDTH-1:0]                   addr,
    input  logic                                        wr_data_rdy,
    output logic [DDR_DATA_WIDTH-1:0]                   wr_data,
    output logic                                        wr_data_en,
    output logic                                        wr_data_end,
    output logic [DDR_DATA_WIDTH/8-1:0]                 wr_data_mask,
    input  logic [DDR_DATA_WIDTH-1:0]                   rd_data,
    input  logic                                        rd_data_valid,
    input  logic                                        rd_data_end
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PAW   = PORT_ADDR_WIDTH;

    arb_state_t state, state_nxt;

    logic [NUM_PORTS-1:0][PAW-1:0]        req_addr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_data;
    logic [NUM_PORTS-1:0][DQM_WIDTH-1:0]  req_be;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] q_r;
    logic [NUM_PORTS-1:0]                 req_wr, pending, ready_r, take, hit, hit_pend;
    logic [IDX_W-1:0]                     grant_idx, rr_ptr, pick, pick_start;
    logic                                 pick_vld, cur_wr, cmd_acc, data_acc;
    logic [DDR_DATA_WIDTH-1:0]            rd_line, cur_wdata;
    logic [DDR_DATA_WIDTH/8-1:0]          cur_mask;
    logic [PAW-1:0]                       cur_addr;
    logic [1:0]                           cur_lane;
    logic                                 unused_rd_end;

    // Single-beat bursts: valid and end always coincide.
    assign unused_rd_end = rd_data_end;

`ifdef DDR3_LINE_BUFFER_EN
    logic [NUM_PORTS-1:0][DDR_DATA_WIDTH-1:0] line_data;
    logic [NUM_PORTS-1:0][PAW-3:0]            line_tag;
    logic [NUM_PORTS-1:0]                     line_vld;

    always_comb begin
        hit = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            hit[p] = take[p] & ~port_wr[p] & line_vld[p] & (line_tag[p] == port_addr[p][PAW-1:2]);
    end
`else
    assign hit      = '0;
    assign hit_pend = '0;
`endif

    assign port_available = {NUM_PORTS{init_complete}} & ~pending & ~hit_pend & ~ready_r;
    assign take           = port_available & (port_rd | port_wr);
    assign port_ready     = ready_r;
    assign port_q         = q_r;

    assign pick_start = (ARB_MODE != 0) ? rr_ptr : '0;

    ddr3_arb_rr_pick #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
        .pending   (pending),
        .start     (pick_start),
        .grant     (pick),
        .grant_vld (pick_vld)
    );

    assign cur_addr  = req_addr[grant_idx];
    assign cur_lane  = cur_addr[1:0];
    assign cur_wdata = {LANES{req_data[grant_idx]}};
    assign cur_mask  = lane_mask(cur_lane, req_be[grant_idx]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pending) state_nxt = ARB;
            ARB:     state_nxt = pick_vld ? CMD : IDLE;
            CMD:     if ((cmd_acc | cmd_ready) && (!cur_wr || data_acc || wr_data_rdy))
                         state_nxt = cur_wr ? DONE : RD_WAIT;
            RD_WAIT: if (rd_data_valid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd          = DDR_CMD_WRITE;
        cmd_en       = 1'b0;
        addr         = '0;
        wr_data      = '0;
        wr_data_en   = 1'b0;
        wr_data_mask = '0;
        if (state == CMD) begin
            cmd_en = ~cmd_acc;
            cmd    = cur_wr ? DDR_CMD_WRITE : DDR_CMD_READ;
            addr   = DDR_ADDR_WIDTH'({cur_addr[PAW-1:2], 3'b000});
            if (cur_wr) begin
                wr_data_en   = ~data_acc;
                wr_data      = cur_wdata;
                wr_data_mask = cur_mask;
            end
        end
    end
    assign wr_data_end = wr_data_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_complete <= 1'b0;
            req_addr      <= '0;
            req_data      <= '0;
            req_be        <= '0;
            req_wr        <= '0;
            pending       <= '0;
            ready_r       <= '0;
            q_r           <= '0;
            grant_idx     <= '0;
            rr_ptr        <= '0;
            cur_wr        <= 1'b0;
            cmd_acc       <= 1'b0;
            data_acc      <= 1'b0;
            rd_line       <= '0;
        end else begin
            init_complete <= init_calib_complete;
            ready_r       <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (take[p]) begin
                    req_addr[p] <= port_addr[p];
                    req_data[p] <= port_data[p];
                    req_be[p]   <= port_byte_en[p];
                    req_wr[p]   <= port_wr[p];
                    pending[p]  <= ~hit[p];
                end
            end
            if (state == ARB && pick_vld) begin
                grant_idx <= pick;
                cur_wr    <= req_wr[pick];
                rr_ptr    <= (pick == IDX_W'(NUM_PORTS - 1)) ? '0 : pick + 1'b1;
            end
            // Acceptance flags live only while in CMD so each strobe drops on its own ack.
            cmd_acc  <= (state == CMD) & (cmd_acc | cmd_ready);
            data_acc <= (state == CMD) & (data_acc | (cur_wr & wr_data_rdy));
            if (state == RD_WAIT && rd_data_valid)
                rd_line <= rd_data;
            if (state == DONE) begin
                pending[grant_idx] <= 1'b0;
                ready_r[grant_idx] <= 1'b1;
                if (!cur_wr)
                    q_r[grant_idx] <= rd_line[{cur_lane, 5'b0} +: DATA_WIDTH];
            end
`ifdef DDR3_LINE_BUFFER_EN
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (hit_pend[p]) begin
                    ready_r[p] <= 1'b1;
                    q_r[p]     <= line_data[p][{req_addr[p][1:0], 5'b0} +: DATA_WIDTH];
                end
            end
`endif
        end
    end

`ifdef DDR3_LINE_BUFFER_EN
    // Writes from any port are merged into every matching valid line to keep them coherent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_data <= '0;
            line_tag  <= '0;
            line_vld  <= '0;
            hit_pend  <= '0;
        end else begin
            hit_pend <= hit;
            if (state == DONE) begin
                if (!cur_wr) begin
                    line_data[grant_idx] <= rd_line;
                    line_tag[grant_idx]  <= cur_addr[PAW-1:2];
                    line_vld[grant_idx]  <= 1'b1;
                end else begin
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (line_vld[p] && line_tag[p] == cur_addr[PAW-1:2]) begin
                            for (int b = 0; b < DDR_DATA_WIDTH / 8; b++)
                                if (!cur_mask[b]) line_data[p][8*b +: 8] <= cur_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed bench for ddr3_port_arbiter: writes, reads, round-robin order, command stall,
// mid-transaction reset and (with DDR3_LINE_BUFFER_EN) line-buffer hit/merge.
module tb_ddr3_port_arbiter;

    localparam int NP  = 4;
    localparam int PAW = 27;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      init_complete;
    logic [NP-1:0][PAW-1:0]    port_addr;
    logic [NP-1:0][31:0]       port_data;
    logic [NP-1:0][3:0]        port_byte_en;
    logic [NP-1:0]             port_wr, port_rd;
    logic [NP-1:0][31:0]       port_q;
    logic [NP-1:0]             port_available, port_ready;
    logic                      init_calib_complete, cmd_ready, cmd_en;
    logic [2:0]                cmd;
    logic [28:0]               addr;
    logic                      wr_data_rdy, wr_data_en, wr_data_end;
    logic [127:0]              wr_data, rd_data;
    logic [15:0]               wr_data_mask;
    logic                      rd_data_valid, rd_data_end;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    ddr3_port_arbiter dut (
        .clk(clk), .reset_n(reset_n), .init_complete(init_complete),
        .port_addr(port_addr), .port_data(port_data), .port_byte_en(port_byte_en),
        .port_wr(port_wr), .port_rd(port_rd), .port_q(port_q),
        .port_available(port_available), .port_ready(port_ready),
        .init_calib_complete(init_calib_complete), .cmd_ready(cmd_ready), .cmd(cmd),
        .cmd_en(cmd_en), .addr(addr), .wr_data_rdy(wr_data_rdy), .wr_data(wr_data),
        .wr_data_en(wr_data_en), .wr_data_end(wr_data_end), .wr_data_mask(wr_data_mask),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_end(rd_data_end)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input int p, input logic wr, input logic rd, input logic [PAW-1:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        for (int i = 0; i < 60 && !port_available[p]; i++) tick;
        chk("avail_before_req", port_available[p], 1'b1);
        port_addr[p] = a; port_data[p] = d; port_byte_en[p] = be;
        port_wr[p] = wr; port_rd[p] = rd;
        tick;
        port_wr[p] = 1'b0; port_rd[p] = 1'b0;
        chk("avail_drop", port_available[p], 1'b0);
    endtask

    task automatic wait_cmd;
        for (int i = 0; i < 60 && !cmd_en; i++) tick;
        chk("cmd_en_seen", cmd_en, 1'b1);
    endtask

    task automatic serve_write(input logic [28:0] ea, input logic [15:0] em, input logic [127:0] ed,
                               input logic split);
        wait_cmd;
        chk("wr_cmd", cmd, 3'b000);
        chk("wr_addr", addr, ea);
        chk("wr_mask", wr_data_mask, em);
        chk("wr_data", wr_data, ed);
        chk("wr_en_end", {wr_data_en, wr_data_end}, 2'b11);
        if (split) begin
            cmd_ready = 1'b1;
            tick;
            cmd_ready = 1'b0;
            chk("split_cmd_dropped", cmd_en, 1'b0);
            chk("split_data_held", wr_data_en, 1'b1);
            tick;
            wr_data_rdy = 1'b1;
            tick;
            wr_data_rdy = 1'b0;
        end else begin
            cmd_ready = 1'b1; wr_data_rdy = 1'b1;
            tick;
            cmd_ready = 1'b0; wr_data_rdy = 1'b0;
        end
        chk("wr_strobes_low", {cmd_en, wr_data_en}, 2'b00);
    endtask

    task automatic serve_read(input logic [28:0] ea, input logic [127:0] line);
        wait_cmd;
        chk("rd_cmd", cmd, 3'b001);
        chk("rd_addr", addr, ea);
        cmd_ready = 1'b1;
        tick;
        cmd_ready = 1'b0;
        tick;
        tick;
        rd_data = line; rd_data_valid = 1'b1; rd_data_end = 1'b1;
        tick;
        rd_data_valid = 1'b0; rd_data_end = 1'b0;
    endtask

    task automatic wait_ready(input int p, input logic check_q, input logic [31:0] eq);
        for (int i = 0; i < 30 && !port_ready[p]; i++) tick;
        chk("ready_pulse", port_ready[p], 1'b1);
        if (check_q) chk("q_value", port_q[p], eq);
        tick;
        chk("ready_one_cycle", port_ready[p], 1'b0);
        chk("avail_after_ready", port_available[p], 1'b1);
    endtask

    initial begin
        int ord[4];
        ord = '{1, 2, 3, 0};
        reset_n = 1'b0; init_calib_complete = 1'b0;
        port_addr = '0; port_data = '0; port_byte_en = '0; port_wr = '0; port_rd = '0;
        cmd_ready = 1'b0; wr_data_rdy = 1'b0; rd_data = '0; rd_data_valid = 1'b0; rd_data_end = 1'b0;
        tick;
        tick;
        chk("rst_init", init_complete, 1'b0);
        chk("rst_avail", port_available, 4'h0);
        chk("rst_ready", port_ready, 4'h0);
        chk("rst_strobes", {cmd_en, wr_data_en, wr_data_end}, 3'b000);
        chk("rst_addr", addr, 29'h0);
        chk("rst_q", port_q, 128'h0);
        reset_n = 1'b1;
        tick;
        chk("avail_before_init", port_available, 4'h0);
        init_calib_complete = 1'b1;
        tick;
        tick;
        chk("init_done", init_complete, 1'b1);
        chk("avail_after_init", port_available, 4'hF);

        // port0 write, command and data acked in different cycles
        request(0, 1'b1, 1'b0, 27'h10, 32'hDEADBEEF, 4'hF);
        serve_write(29'h20, 16'hFFF0, {4{32'hDEADBEEF}}, 1'b1);
        wait_ready(0, 1'b0, 32'h0);

        // port1 read back
        request(1, 1'b0, 1'b1, 27'h10, 32'h0, 4'h0);
        serve_read(29'h20, {96'h0123_4567_89AB_CDEF_5555_AAAA, 32'hDEADBEEF});
        wait_ready(1, 1'b1, 32'hDEADBEEF);

        // rd+wr together on lane 3: write wins
        request(3, 1'b1, 1'b1, 27'h13, 32'hCAFEF00D, 4'b0101);
        serve_write(29'h20, 16'hAFFF, {4{32'hCAFEF00D}}, 1'b0);
        wait_ready(3, 1'b0, 32'h0);

        // round robin: four simultaneous reads from pointer 0
        for (int p = 0; p < NP; p++) port_addr[p] = 27'(27'h100 + 4 * p);
        port_rd = 4'hF;
        tick;
        port_rd = 4'h0;
        chk("rr_all_latched", port_available, 4'h0);
        for (int k = 0; k < NP; k++) begin
            serve_read(29'(29'h200 + 8 * k), {96'h0, 32'(32'hA0 + k)});
            wait_ready(k, 1'b1, 32'(32'hA0 + k));
        end

        // single port0 grant moves pointer to 1, then the next round goes 1,2,3,0
        request(0, 1'b0, 1'b1, 27'h180, 32'h0, 4'h0);
        serve_read(29'h300, {96'h0, 32'h1234_5678});
        wait_ready(0, 1'b1, 32'h1234_5678);
        for (int p = 0; p < NP; p++) port_addr[p] = 27'(27'h200 + 4 * p);
        port_rd = 4'hF;
        tick;
        port_rd = 4'h0;
        for (int k = 0; k < NP; k++) begin
            serve_read(29'(29'h400 + 8 * ord[k]), {96'h0, 32'(32'hB0 + ord[k])});
            wait_ready(ord[k], 1'b1, 32'(32'hB0 + ord[k]));
        end

        // cmd_ready withheld 20 cycles; port2 request arrives meanwhile
        request(0, 1'b0, 1'b1, 27'h20, 32'h0, 4'h0);
        wait_cmd;
        port_addr[2] = 27'h30;
        for (int i = 0; i < 20; i++) begin
            chk("stall_cmd_en", cmd_en, 1'b1);
            chk("stall_addr", addr, 29'h40);
            port_rd[2] = (i == 5);
            tick;
        end
        port_rd[2] = 1'b0;
        chk("stall_p2_latched", port_available[2], 1'b0);
        serve_read(29'h40, {64'h0, 32'h7777_0000, 32'h0000_7777});
        wait_ready(0, 1'b1, 32'h0000_7777);
        serve_read(29'h60, {96'h0, 32'h2222_2222});
        wait_ready(2, 1'b1, 32'h2222_2222);

        // reset in RD_WAIT, late read data ignored, gated by calibration
        request(0, 1'b0, 1'b1, 27'h50, 32'h0, 4'h0);
        wait_cmd;
        cmd_ready = 1'b1;
        tick;
        cmd_ready = 1'b0;
        tick;
        reset_n = 1'b0; init_calib_complete = 1'b0;
        #1;
        chk("abort_strobes", {cmd_en, wr_data_en}, 2'b00);
        chk("abort_avail", port_available, 4'h0);
        chk("abort_init", init_complete, 1'b0);
        tick;
        reset_n = 1'b1;
        tick;
        rd_data = {96'h0, 32'hBAD0BAD0}; rd_data_valid = 1'b1; rd_data_end = 1'b1;
        tick;
        rd_data_valid = 1'b0; rd_data_end = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("late_valid_no_ready", port_ready, 4'h0);
            chk("late_valid_no_cmd", cmd_en, 1'b0);
            tick;
        end
        chk("no_avail_uncalibrated", port_available, 4'h0);
        init_calib_complete = 1'b1;
        tick;
        tick;
        chk("avail_recalibrated", port_available, 4'hF);

`ifdef DDR3_LINE_BUFFER_EN
        // miss fill, coherent merge from another port, then a 2-cycle hit without a command
        request(0, 1'b0, 1'b1, 27'h40, 32'h0, 4'h0);
        serve_read(29'h80, 128'h44444444_33333333_22222222_11111111);
        wait_ready(0, 1'b1, 32'h11111111);
        request(1, 1'b1, 1'b0, 27'h41, 32'hAABBCCDD, 4'h3);
        serve_write(29'h80, 16'hFFCF, {4{32'hAABBCCDD}}, 1'b0);
        wait_ready(1, 1'b0, 32'h0);
        request(0, 1'b0, 1'b1, 27'h41, 32'h0, 4'h0);
        chk("hit_no_cmd_1", cmd_en, 1'b0);
        chk("hit_not_yet", port_ready[0], 1'b0);
        tick;
        chk("hit_ready", port_ready[0], 1'b1);
        chk("hit_merged_q", port_q[0], 32'h2222CCDD);
        chk("hit_no_cmd_2", cmd_en, 1'b0);
        tick;
        chk("hit_avail_back", port_available[0], 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
